lms_adapt_ctrl: RTL and testbench

//  Sequencer for the LMS adaptive filter: streams samples into it, schedules its step size.

---
 rtl/lms_ctrl_pkg.sv | 30 +++
 rtl/lms_adapt_ctrl_err_window_acc.sv | 63 ++++++
 rtl/lms_adapt_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lms_adapt_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_ctrl_pkg.sv
// Shared definitions for the LMS adaptation controller.
//   ctrl_state_t : 3-bit controller state, encoding visible on o_state
//   DEF_WIDTH    : default sample/error/step width
//   DEF_FRAC     : default fractional bit count (shared with the filter)
//   sat_abs()    : magnitude of a sign-extended value, clipped to 2**(w-1)-1
package lms_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_FRAC  = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_TRACK  = 3'd2,
        ST_FROZEN = 3'd3,
        ST_FAULT  = 3'd4
    } ctrl_state_t;

    // The most negative w-bit input has no positive w-bit counterpart, so the
    // magnitude is clipped to the largest positive w-bit value.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x,
                                            input int unsigned       w);
        logic [63:0] mag;
        logic [63:0] lim;
        mag = x[63] ? unsigned'(-x) : unsigned'(x);
        lim = (64'd1 << (w - 1)) - 64'd1;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/lms_adapt_ctrl_err_window_acc.sv
// Windowed mean |error| accumulator (module err_window_acc).
// Saturates |err|, sums 2**WIN_LOG2 valid results, then latches the mean and
// restarts the sum in the same cycle.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : discard partial window (sum and sample count)
//   pause     : ignore valid results while set
//   valid     : err carries a result that belongs to the window
//   err       : signed filter error
//   done      : one-cycle pulse after a window closes
//   mean      : mean |error| of the last completed window
module err_window_acc
    import lms_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             pause,
    input  logic             valid,
    input  logic [WIDTH-1:0] err,
    output logic             done,
    output logic [WIDTH-1:0] mean
);

    localparam int unsigned AW = WIDTH + WIN_LOG2;

    logic [AW-1:0]       acc;
    logic [AW-1:0]       sum;
    logic [WIN_LOG2-1:0] cnt;
    logic [WIDTH-1:0]    mag;

    always_comb begin
        mag = WIDTH'(sat_abs(64'(signed'(err)), WIDTH));
        sum = acc + AW'(mag);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            mean <= '0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (valid && !pause) begin
                cnt <= cnt + WIN_LOG2'(1);
                if (cnt == '1) begin
                    mean <= WIDTH'(sum >> WIN_LOG2);
                    acc  <= '0;
                    done <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptive filter sequencer: forwards accepted samples to the filter,
// schedules the step size over TRAIN/TRACK phases from the windowed mean
// |error|, and clears the filter weights on arithmetic overflow.
// Optional build macro LMS_CTRL_STEP_DECAY_EN: TRAIN step halves at every
// window close (floored at i_step_min); otherwise TRAIN step is constant.
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   i_start / i_freeze               restart pulse / weight-hold level
//   i_step_init/i_step_min           TRAIN start step / floor and TRACK step
//   i_conv_thresh                    mean |error| convergence threshold
//   s_valid/s_ready/s_din/s_desired  sample stream in
//   o_flt_din/o_flt_desired/o_flt_step/o_flt_rstn  filter drive
//   i_flt_error/i_flt_ovr            filter results, FLT_LAT after o_flt_din
//   o_state/o_converged/o_timeout/o_fault/o_mean_err  status
module lms_adapt_ctrl
    import lms_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned FRAC      = DEF_FRAC,
    parameter int unsigned WIN_LOG2  = 4,
    parameter int unsigned CONV_WINS = 3,
    parameter int unsigned DIV_WINS  = 2,
    parameter int unsigned MAX_WINS  = 256,
    parameter int unsigned FLT_LAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_freeze,
    input  logic [WIDTH-1:0] i_step_init,
    input  logic [WIDTH-1:0] i_step_min,
    input  logic [WIDTH-1:0] i_conv_thresh,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_din,
    input  logic [WIDTH-1:0] s_desired,
    output logic [WIDTH-1:0] o_flt_din,
    output logic [WIDTH-1:0] o_flt_desired,
    output logic [WIDTH-1:0] o_flt_step,
    output logic             o_flt_rstn,
    input  logic [WIDTH-1:0] i_flt_error,
    input  logic             i_flt_ovr,
    output logic [2:0]       o_state,
    output logic             o_converged,
    output logic             o_timeout,
    output logic             o_fault,
    output logic [WIDTH-1:0] o_mean_err
);

    localparam int unsigned CW = $clog2(CONV_WINS + 1);
    localparam int unsigned DW = $clog2(DIV_WINS + 1);
    localparam int unsigned WW = $clog2(MAX_WINS + 1);

    if (FRAC >= WIDTH || WIDTH > 64) begin : g_bad_width
        $error("lms_adapt_ctrl: need FRAC < WIDTH <= 64");
    end

    ctrl_state_t      state, state_n, saved, saved_n;
    logic [WIDTH-1:0] step, step_n, step_dec, init_eff;
    logic [CW-1:0]    below, below_n;
    logic [DW-1:0]    above, above_n;
    logic [WW-1:0]    wins, wins_n;
    logic             timeout_n, flush, accept, ovr_hit, phase_run;
    logic [FLT_LAT:0] tag_vld, tag_cnt;
    logic             win_done;

    assign accept    = s_valid && s_ready;
    assign phase_run = (state == ST_TRAIN) || (state == ST_TRACK);

    // Samples accepted while FROZEN still reach the filter (tag_vld, for the
    // overflow check) but never enter the error window (tag_cnt).
    err_window_acc #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_acc (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (flush),
        .pause (!phase_run),
        .valid (tag_cnt[FLT_LAT]),
        .err   (i_flt_error),
        .done  (win_done),
        .mean  (o_mean_err)
    );

    always_comb begin
        init_eff  = (i_step_init < i_step_min) ? i_step_min : i_step_init;
`ifdef LMS_CTRL_STEP_DECAY_EN
        step_dec  = ((step >> 1) < i_step_min) ? i_step_min : (step >> 1);
`else
        step_dec  = step;
`endif
        ovr_hit   = (phase_run || state == ST_FROZEN) && tag_vld[FLT_LAT] && i_flt_ovr;
        state_n   = state;
        saved_n   = saved;
        step_n    = step;
        below_n   = below;
        above_n   = above;
        wins_n    = wins;
        timeout_n = o_timeout;
        flush     = 1'b0;
        if (ovr_hit) begin
            state_n = ST_FAULT;
            flush   = 1'b1;
        end else if (i_start) begin
            state_n   = ST_TRAIN;
            saved_n   = ST_TRAIN;
            step_n    = init_eff;
            below_n   = '0;
            above_n   = '0;
            wins_n    = '0;
            timeout_n = 1'b0;
            flush     = 1'b1;
        end else begin
            case (state)
                ST_TRAIN, ST_TRACK: begin
                    if (i_freeze) begin
                        saved_n = state;
                        state_n = ST_FROZEN;
                    end else if (win_done && state == ST_TRAIN) begin
                        if (wins != WW'(MAX_WINS)) wins_n = wins + WW'(1);
                        if (wins_n == WW'(MAX_WINS)) timeout_n = 1'b1;
                        if (o_mean_err < i_conv_thresh) begin
                            if (below + CW'(1) == CW'(CONV_WINS)) begin
                                state_n = ST_TRACK;
                                step_n  = i_step_min;
                                below_n = '0;
                                above_n = '0;
                            end else begin
                                below_n = below + CW'(1);
                                step_n  = step_dec;
                            end
                        end else begin
                            below_n = '0;
                            step_n  = step_dec;
                        end
                    end else if (win_done) begin
                        if (o_mean_err >= i_conv_thresh) begin
                            if (above + DW'(1) == DW'(DIV_WINS)) begin
                                state_n = ST_TRAIN;
                                step_n  = init_eff;
                                below_n = '0;
                                above_n = '0;
                            end else begin
                                above_n = above + DW'(1);
                            end
                        end else begin
                            above_n = '0;
                        end
                    end
                end
                ST_FROZEN: if (!i_freeze) state_n = saved;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            saved         <= ST_TRAIN;
            step          <= '0;
            below         <= '0;
            above         <= '0;
            wins          <= '0;
            tag_vld       <= '0;
            tag_cnt       <= '0;
            s_ready       <= 1'b0;
            o_flt_din     <= '0;
            o_flt_desired <= '0;
            o_flt_step    <= '0;
            o_flt_rstn    <= 1'b0;
            o_state       <= ST_IDLE;
            o_converged   <= 1'b0;
            o_timeout     <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            state       <= state_n;
            saved       <= saved_n;
            step        <= step_n;
            below       <= below_n;
            above       <= above_n;
            wins        <= wins_n;
            s_ready     <= (state_n == ST_TRAIN) || (state_n == ST_TRACK) ||
                           (state_n == ST_FROZEN);
            o_flt_rstn  <= !flush && (state_n != ST_IDLE);
            o_state     <= state_n;
            o_converged <= (state_n == ST_TRACK);
            o_fault     <= (state_n == ST_FAULT);
            o_timeout   <= timeout_n;
            if (accept) begin
                o_flt_din     <= s_din;
                o_flt_desired <= s_desired;
                o_flt_step    <= (state == ST_FROZEN) ? '0 : step;
            end else begin
                o_flt_din     <= '0;
                o_flt_desired <= '0;
                o_flt_step    <= '0;
            end
            if (flush) begin
                tag_vld <= '0;
                tag_cnt <= '0;
            end else begin
                tag_vld <= (FLT_LAT + 1)'({tag_vld, accept});
                tag_cnt <= (FLT_LAT + 1)'({tag_cnt, accept && (state != ST_FROZEN)});
            end
        end
    end

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Scoreboard bench for lms_adapt_ctrl: the stimulus thread pushes the expected
// filter drive for every accepted sample; a negedge monitor pops and compares.
module tb_lms_adapt_ctrl;

    localparam logic [31:0] INIT = 32'h0001_0000;
    localparam logic [31:0] MINS = 32'h0000_2000;
    localparam logic [31:0] THR  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rstn, i_start, i_freeze, s_valid, i_flt_ovr;
    logic [31:0] i_step_init, i_step_min, i_conv_thresh, s_din, s_desired, i_flt_error;
    logic        s_ready, o_flt_rstn, o_converged, o_timeout, o_fault;
    logic [31:0] o_flt_din, o_flt_desired, o_flt_step, o_mean_err;
    logic [2:0]  o_state;

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] des;
        logic [31:0] step;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          pend   = 1'b0;
    logic [31:0] exp_step;
    logic [31:0] sample_id = 32'd1;

    always #5 clk = ~clk;

    lms_adapt_ctrl #(
        .MAX_WINS (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (i_start),
        .i_freeze      (i_freeze),
        .i_step_init   (i_step_init),
        .i_step_min    (i_step_min),
        .i_conv_thresh (i_conv_thresh),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_din         (s_din),
        .s_desired     (s_desired),
        .o_flt_din     (o_flt_din),
        .o_flt_desired (o_flt_desired),
        .o_flt_step    (o_flt_step),
        .o_flt_rstn    (o_flt_rstn),
        .i_flt_error   (i_flt_error),
        .i_flt_ovr     (i_flt_ovr),
        .o_state       (o_state),
        .o_converged   (o_converged),
        .o_timeout     (o_timeout),
        .o_fault       (o_fault),
        .o_mean_err    (o_mean_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] decay(input logic [31:0] s);
`ifdef LMS_CTRL_STEP_DECAY_EN
        return ((s >> 1) < MINS) ? MINS : (s >> 1);
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_next();
        int unsigned n;
        logic [31:0] d, q;
        n = 0;
        d = 32'h1000_0000 + sample_id;
        q = 32'h2000_0000 + sample_id;
        sample_id = sample_id + 32'd1;
        s_valid = 1'b1;
        s_din = d;
        s_desired = q;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (s_ready) sb.push_back('{din: d, des: q, step: exp_step});
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic window();
        repeat (16) send_next();
        repeat (5) tick();
    endtask

    // Monitor: one cycle after each accept the filter drive must match the
    // scoreboard head; every other cycle it must be an all-zero bubble.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pend) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: output seen, no expected entry");
                    end else begin
                        e = sb.pop_front();
                        chk("flt_din", o_flt_din, e.din);
                        chk("flt_desired", o_flt_desired, e.des);
                        chk("flt_step", o_flt_step, e.step);
                    end
                end else begin
                    chk("bubble", o_flt_din | o_flt_desired | o_flt_step, 32'd0);
                end
            end
            pend = mon_en && s_valid && s_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; i_start = 1'b0; i_freeze = 1'b0; s_valid = 1'b0; i_flt_ovr = 1'b0;
        i_step_init = INIT; i_step_min = MINS; i_conv_thresh = THR;
        s_din = '0; s_desired = '0; i_flt_error = '0; exp_step = '0;
        repeat (3) tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_flt_rstn", 32'(o_flt_rstn), 32'd0);
        chk("rst_data", o_flt_din | o_flt_desired | o_flt_step, 32'd0);
        chk("rst_flags", 32'({o_converged, o_timeout, o_fault}), 32'd0);
        chk("rst_mean", o_mean_err, 32'd0);
        mon_en = 1'b1;
        rstn = 1'b1;
        tick();
        chk("idle_hold", 32'(o_state), 32'd0);

        // Start: TRAIN, filter reset for exactly one cycle.
        i_start = 1'b1; tick(); i_start = 1'b0;
        exp_step = INIT;
        chk("start_state", 32'(o_state), 32'd1);
        chk("start_flt_rstn", 32'(o_flt_rstn), 32'd0);
        chk("start_s_ready", 32'(s_ready), 32'd1);
        tick();
        chk("start_flt_rstn_rel", 32'(o_flt_rstn), 32'd1);

        // Test 1: three low-error windows converge.
        i_flt_error = 32'h0000_0419;
        for (int w = 0; w < 3; w++) begin
            window();
            exp_step = (w == 2) ? MINS : decay(exp_step);
        end
        chk("t1_state", 32'(o_state), 32'd2);
        chk("t1_converged", 32'(o_converged), 32'd1);
        chk("t1_mean", o_mean_err, 32'h0000_0419);

        // Test 2: two high-error windows in TRACK fall back to TRAIN.
        i_flt_error = 32'h0010_0000;
        window();
        chk("t2_state_one_win", 32'(o_state), 32'd2);
        window();
        exp_step = INIT;
        chk("t2_state", 32'(o_state), 32'd1);
        chk("t2_converged", 32'(o_converged), 32'd0);
        chk("t2_mean", o_mean_err, 32'h0010_0000);

        // Test 3: tagged overflow mid-window.
        i_flt_error = 32'h0000_0419;
        repeat (6) send_next();
        i_flt_ovr = 1'b1; tick(); i_flt_ovr = 1'b0;
        chk("t3_flt_rstn", 32'(o_flt_rstn), 32'd0);
        chk("t3_state", 32'(o_state), 32'd4);
        chk("t3_fault", 32'(o_fault), 32'd1);
        chk("t3_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk("t3_flt_rstn_rel", 32'(o_flt_rstn), 32'd1);
        chk("t3_state_hold", 32'(o_state), 32'd4);
        s_valid = 1'b1; repeat (3) tick(); s_valid = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        exp_step = INIT;
        chk("t3_restart_state", 32'(o_state), 32'd1);
        chk("t3_restart_rstn", 32'(o_flt_rstn), 32'd0);
        chk("t3_restart_fault", 32'(o_fault), 32'd0);
        tick();

        // Test 4: freeze pauses the window; frozen samples carry step 0.
        i_flt_error = 32'h0000_0800;
        repeat (8) send_next();
        repeat (3) tick();
        i_freeze = 1'b1; tick(); tick();
        chk("t4_state_frozen", 32'(o_state), 32'd3);
        chk("t4_s_ready", 32'(s_ready), 32'd1);
        exp_step = 32'd0;
        i_flt_error = 32'h0700_0000;
        repeat (5) send_next();
        repeat (3) tick();
        chk("t4_mean_hold", o_mean_err, 32'h0010_0000);
        i_freeze = 1'b0;
        i_flt_error = 32'h0000_0800;
        tick(); tick();
        chk("t4_state_resume", 32'(o_state), 32'd1);
        exp_step = INIT;
        repeat (7) send_next();
        repeat (5) tick();
        chk("t4_window_not_early", o_mean_err, 32'h0010_0000);
        send_next();
        repeat (5) tick();
        exp_step = decay(exp_step);
        chk("t4_mean", o_mean_err, 32'h0000_0800);
        chk("t4_state", 32'(o_state), 32'd1);

        // Test 5: never below threshold, timeout after four TRAIN windows.
        i_start = 1'b1; tick(); i_start = 1'b0;
        exp_step = INIT;
        i_flt_error = 32'h0000_2000;
        for (int w = 0; w < 5; w++) begin
            window();
            exp_step = decay(exp_step);
            if (w == 2) chk("t5_no_timeout_yet", 32'(o_timeout), 32'd0);
            if (w == 3) begin
                chk("t5_timeout", 32'(o_timeout), 32'd1);
                chk("t5_state", 32'(o_state), 32'd1);
            end
        end
        chk("t5_timeout_sticky", 32'(o_timeout), 32'd1);
        chk("t5_state_train", 32'(o_state), 32'd1);
        chk("t5_mean", o_mean_err, 32'h0000_2000);

        // Step floor and |error| saturation.
        i_step_init = 32'h0000_1000;
        i_start = 1'b1; tick(); i_start = 1'b0;
        chk("floor_timeout_clr", 32'(o_timeout), 32'd0);
        exp_step = MINS;
        i_flt_error = 32'hFFFF_FBE7;
        window();
        chk("neg_err_mean", o_mean_err, 32'h0000_0419);
        i_flt_error = 32'h8000_0000;
        window();
        chk("sat_err_mean", o_mean_err, 32'h7FFF_FFFF);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
